// File: rtl/bn_pkg.sv
// bn_pkg: shared widths, frame geometry defaults and parameter-select encodings
package bn_pkg;
  localparam int W1_DEF = 27;
  localparam int W2_DEF = 18;
  localparam int NCH_DEF = 8;
  localparam int NPIX_DEF = 16;
  localparam logic [1:0] SEL_DELTA = 2'd0;
  localparam logic [1:0] SEL_MU = 2'd1;
  localparam logic [1:0] SEL_BETA = 2'd2;
endpackage

// File: rtl/bn_param_regfile.sv
// bn_param_regfile: per-channel delta/mu/beta table, one write port, one combinational 3-wide read port
module bn_param_regfile
  import bn_pkg::*;
#(
  parameter int W2 = W2_DEF,
  parameter int NCH = NCH_DEF,
  localparam int AW = $clog2(NCH)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wsel,
  input  logic [W2-1:0] wdata,
  input  logic [AW-1:0] rch,
  output logic [W2-1:0] rdelta,
  output logic [W2-1:0] rmu,
  output logic [W2-1:0] rbeta
);
  logic [W2-1:0] delta [NCH];
  logic [W2-1:0] mu [NCH];
  logic [W2-1:0] beta [NCH];
  // out-of-range addresses and sel=3 match no entry, so they are silently dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        delta[c] <= '0;
        mu[c] <= '0;
        beta[c] <= '0;
      end
    end else if (we) begin
      for (int c = 0; c < NCH; c++)
        if (waddr == AW'(c)) begin
          if (wsel == SEL_DELTA) delta[c] <= wdata;
          if (wsel == SEL_MU) mu[c] <= wdata;
          if (wsel == SEL_BETA) beta[c] <= wdata;
        end
    end
  assign rdelta = delta[rch];
  assign rmu = mu[rch];
  assign rbeta = beta[rch];
endmodule

// File: rtl/bn_param_seq.sv
// bn_param_seq: tags conv samples with channel BN params; BN_PARAM_LOCK_EN rejects table writes mid-frame
module bn_param_seq
  import bn_pkg::*;
#(
  parameter int W1 = W1_DEF,
  parameter int W2 = W2_DEF,
  parameter int NCH = NCH_DEF,
  parameter int NPIX = NPIX_DEF,
  localparam int AW = $clog2(NCH),
  localparam int PW = $clog2(NPIX)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [1:0]    cfg_sel,
  input  logic [W2-1:0] cfg_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W1-1:0] s_din,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [W1-1:0] m_din,
  output logic [W2-1:0] m_delta,
  output logic [W2-1:0] m_mu,
  output logic [W2-1:0] m_beta,
  output logic [AW-1:0] m_ch,
  output logic          m_last,
  output logic          busy,
  output logic          cfg_err
);
  logic          hs, pix_wrap, last_in, we_ok;
  logic [AW-1:0] ch_cnt;
  logic [PW-1:0] pix_cnt;
  logic [W2-1:0] rd_d, rd_m, rd_b;
  assign s_ready = !m_valid || m_ready;
  assign hs = s_valid && s_ready;
  assign pix_wrap = pix_cnt == PW'(NPIX - 1);
  assign last_in = pix_wrap && ch_cnt == AW'(NCH - 1);
`ifdef BN_PARAM_LOCK_EN
  assign we_ok = cfg_we && !busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_err <= 1'b0;
    else cfg_err <= cfg_we && busy;
`else
  assign we_ok = cfg_we;
  assign cfg_err = 1'b0;
`endif
  bn_param_regfile #(.W2(W2), .NCH(NCH)) u_tab (
    .clk(clk), .rst_n(rst_n), .we(we_ok), .waddr(cfg_addr), .wsel(cfg_sel), .wdata(cfg_data),
    .rch(ch_cnt), .rdelta(rd_d), .rmu(rd_m), .rbeta(rd_b)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_cnt <= '0;
      ch_cnt <= '0;
      busy <= 1'b0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_ch <= '0;
      m_din <= '0;
      m_delta <= '0;
      m_mu <= '0;
      m_beta <= '0;
    end else if (hs) begin
      pix_cnt <= pix_wrap ? '0 : pix_cnt + 1'b1;
      ch_cnt <= last_in ? '0 : pix_wrap ? ch_cnt + 1'b1 : ch_cnt;
      busy <= !last_in;
      m_valid <= 1'b1;
      m_din <= s_din;
      m_ch <= ch_cnt;
      m_delta <= rd_d;
      m_mu <= rd_m;
      m_beta <= rd_b;
      m_last <= last_in;
    end else if (m_ready) m_valid <= 1'b0;
endmodule

// File: tb/tb_bn_param_seq.sv
// tb_bn_param_seq: random-stimulus bench against a beat-index model of the parameter sequencer
module tb_bn_param_seq;
  localparam int W1 = 27, W2 = 18, NCH = 8, NPIX = 16, AW = 3, FR = NCH * NPIX;
`ifdef BN_PARAM_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [1:0] cfg_sel = '0;
  logic signed [W2-1:0] cfg_data = '0;
  logic signed [W1-1:0] s_din = '0, m_din;
  logic signed [W2-1:0] m_delta, m_mu, m_beta;
  logic [AW-1:0] m_ch;
  logic s_ready, m_valid, m_last, busy, cfg_err;

  bn_param_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_din(s_din), .m_valid(m_valid), .m_ready(m_ready),
    .m_din(m_din), .m_delta(m_delta), .m_mu(m_mu), .m_beta(m_beta), .m_ch(m_ch), .m_last(m_last),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // model: tables, the expected output beat and the beat index inside the frame
  logic signed [W2-1:0] td [NCH], tm [NCH], tbt [NCH];
  logic signed [W1-1:0] e_din;
  logic signed [W2-1:0] e_d, e_m, e_b;
  logic e_valid, e_last, e_busy, e_err;
  int e_ch, beat;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      td[c] = '0;
      tm[c] = '0;
      tbt[c] = '0;
    end
    e_din = '0; e_d = '0; e_m = '0; e_b = '0;
    e_valid = 0; e_last = 0; e_busy = 0; e_err = 0; e_ch = 0; beat = 0;
  endtask

  task automatic model_edge();
    bit acc, lock;
    acc = s_valid && (!e_valid || m_ready);
    lock = LOCK && e_busy;
    e_err = cfg_we && lock;
    if (acc) begin
      e_ch = beat / NPIX;
      e_din = s_din;
      e_d = td[e_ch];
      e_m = tm[e_ch];
      e_b = tbt[e_ch];
      e_last = beat == FR - 1;
      e_busy = !e_last;
      beat = (beat + 1) % FR;
      e_valid = 1;
    end else if (m_ready) e_valid = 0;
    if (cfg_we && !lock && int'(cfg_addr) < NCH) begin
      if (cfg_sel == 2'd0) td[cfg_addr] = cfg_data;
      if (cfg_sel == 2'd1) tm[cfg_addr] = cfg_data;
      if (cfg_sel == 2'd2) tbt[cfg_addr] = cfg_data;
    end
  endtask

  always @(negedge clk) begin
    chk("s_ready", s_ready, !e_valid || m_ready);
    chk("m_valid", m_valid, e_valid);
    chk("busy", busy, e_busy);
    chk("cfg_err", cfg_err, e_err);
    if (e_valid) begin
      chk("m_din", m_din, e_din);
      chk("m_ch", m_ch, e_ch);
      chk("m_delta", m_delta, e_d);
      chk("m_mu", m_mu, e_m);
      chk("m_beta", m_beta, e_b);
      chk("m_last", m_last, e_last);
    end
  end

  task automatic cycle(input bit sv, input logic signed [W1-1:0] d, input bit mr,
                       input bit we = 0, input int a = 0, input int sel = 3, input int data = 0);
    s_valid = sv; s_din = d; m_ready = mr;
    cfg_we = we; cfg_addr = AW'(a); cfg_sel = 2'(sel); cfg_data = W2'(data);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset(input string tag);
    s_valid = 0; m_ready = 0; cfg_we = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_ch"}, m_ch, 0);
    chk({tag, "_m_din"}, m_din, 0);
    chk({tag, "_m_delta"}, m_delta, 0);
    chk({tag, "_m_mu"}, m_mu, 0);
    chk({tag, "_m_beta"}, m_beta, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nlast, lastpos, held;
    model_reset();
    do_reset("reset");
    // ch0 params, then one tagged beat
    cycle(0, 0, 0, 1, 0, 0, 5);
    cycle(0, 0, 0, 1, 0, 1, -3);
    cycle(0, 0, 0, 1, 0, 2, 100);
    cycle(1, 40, 1);
    chk("first_valid", m_valid, 1);
    chk("first_din", m_din, 40);
    chk("first_delta", m_delta, 5);
    chk("first_mu", m_mu, -3);
    chk("first_beta", m_beta, 100);
    chk("first_ch", m_ch, 0);
    // rest of a full frame at full rate
    nlast = 0; lastpos = -1;
    for (int b = 1; b < FR; b++) begin
      cycle(1, W1'($urandom), 1);
      if (m_last) begin nlast++; lastpos = b; end
      if (b == 16) chk("frame_ch1", m_ch, 1);
      if (b == 127) chk("frame_ch7", m_ch, 7);
    end
    chk("last_count", nlast, 1);
    chk("last_pos", lastpos, 127);
    chk("busy_after_frame", busy, 0);
    cycle(1, 7, 1);
    chk("wrap_ch", m_ch, 0);
    chk("wrap_last", m_last, 0);
    chk("wrap_busy", busy, 1);
    // backpressure
    cycle(1, 11, 1);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, W1'($urandom), 0);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_din", m_din, 11);
      chk("bp_valid", m_valid, 1);
    end
    cycle(1, 22, 1);
    chk("bp_release_din", m_din, 22);
    // random handshakes and occasional table writes over several frames
    for (int i = 0; i < 1200; i++)
      cycle($urandom_range(0, 3) != 0, W1'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, NCH - 1), $urandom_range(0, 3),
            int'($urandom_range(0, 2 ** W2 - 1)) - 2 ** (W2 - 1));
    // reset mid-frame at beat 50
    do_reset("align");
    for (int b = 0; b < 50; b++) cycle(1, W1'($urandom), 1);
    do_reset("midrst");
    cycle(0, 0, 1, 1, 2, 1, 1);
    cycle(1, 33, 1);
    chk("postrst_ch", m_ch, 0);
    chk("postrst_din", m_din, 33);
    chk("postrst_delta", m_delta, 0);
    chk("postrst_mu", m_mu, 0);
    chk("postrst_beta", m_beta, 0);
    // mid-frame write of ch2 mu
    cycle(1, W1'($urandom), 1);
    cycle(0, 0, 1, 1, 2, 1, 7);
    chk("lock_err", cfg_err, LOCK);
    for (int b = 2; b < 32; b++) cycle(1, W1'($urandom), 1);
    cycle(1, 55, 1);
    chk("ch2_tag", m_ch, 2);
    chk("ch2_mu", m_mu, LOCK ? 1 : 7);
    repeat (3) cycle(0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bn_param_seq.md
# bn_param_seq

Per-channel parameter sequencer feeding the batch-normalisation stage of the digit-classification CNN. It accepts a stream of convolution-sum samples, counts pixels and channels, and emits each sample aligned with that channel's delta, mu and beta from a locally loaded parameter table. Samples and parameters arrive together in one registered valid/ready beat. Parameters are loaded through a simple write port before or between frames.

## Interface
- W1, 27, sample width (signed)
- W2, 18, parameter width (signed)
- NCH, 8, channels per frame (≥2)
- NPIX, 16, pixels per channel (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  parameter write strobe
- cfg_addr  in  $clog2(NCH)  channel index to write
- cfg_sel  in  2  0=delta, 1=mu, 2=beta, 3=ignored
- cfg_data  in  W2  parameter value
- s_valid  in  1  input sample valid
- s_ready  out  1  input accepted when s_valid&&s_ready
- s_din  in  W1  input sample
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_din  out  W1  registered sample
- m_delta, m_mu, m_beta  out  W2 each  parameters of m_ch
- m_ch  out  $clog2(NCH)  channel of the beat
- m_last  out  1  final beat of frame
- busy  out  1  frame in progress
- cfg_err  out  1  one-cycle pulse, rejected write (macro only)

## Operation
- Parameter table: NCH×3 registers, all reset to 0. A write with cfg_we=1 and cfg_sel≠3 updates entry [cfg_addr][cfg_sel] on the clock edge. cfg_addr≥NCH is ignored.
- Counters: pix_cnt runs 0..NPIX-1 and ch_cnt runs 0..NCH-1. Both advance only on an input handshake.
  - pix_cnt wraps to 0 and increments ch_cnt.
  - When both counters wrap, the frame ends.
- On a handshake, the output register loads:
  - m_din=s_din
  - m_ch=ch_cnt
  - the three params of ch_cnt, read from the table at that edge (pre-write value if a write hits the same edge)
  - m_last=(ch_cnt==NCH-1 && pix_cnt==NPIX-1)
- busy: set on the first handshake of a frame and cleared on the handshake carrying m_last. It stays 0 if NCH·NPIX beats complete in one frame.
- Output register: m_valid sets on an input handshake. It clears when m_ready=1 and there is no new handshake. Output data is held stable while m_valid && !m_ready.
- s_ready = !m_valid || m_ready, combinational from m_ready.
- Arithmetic is none; values pass through bit-exact and sign is preserved.

## Timing
- Reset values: m_valid=0, m_last=0, m_ch=0, m_din=0, m_delta=m_mu=m_beta=0, busy=0, cfg_err=0. Counters and table are 0.
- Latency: 1 cycle from input handshake to m_valid.
- Throughput: 1 beat/cycle when m_ready is held at 1.
- Backpressure: with m_valid=1 and m_ready=0, s_ready=0 and no counter moves.
- Simultaneous output drain and input accept: the register reloads and m_valid stays 1.
- Reset mid-frame: counters, busy and the output register clear immediately. The partial frame is discarded and the table is also cleared.
- A write to the channel currently held in the output register does not alter m_delta/m_mu/m_beta already presented.

## Configuration
- BN_PARAM_LOCK_EN defined: writes with busy=1 are dropped, and cfg_err pulses high for the cycle after the dropped write.
  - A write on the same edge as the m_last handshake is still rejected.
- BN_PARAM_LOCK_EN undefined: writes are always accepted, and take effect for beats fetched on later edges. cfg_err is tied 0.

## Structure
- Package bn_pkg:
  - W1/W2 defaults
  - cfg_sel encodings (SEL_DELTA=0, SEL_MU=1, SEL_BETA=2)
  - NCH/NPIX defaults
- Sub-module bn_param_regfile: NCH×3 table with write port and one combinational 3-wide read port indexed by channel.
- Top holds counters, busy, output register and handshake.

## Test plan
- Load ch0 delta=5, mu=-3, beta=100, then stream s_din=40 with m_ready=1 -> next cycle m_valid=1, m_din=40, m_delta=5, m_mu=-3, m_beta=100, m_ch=0.
- Stream 128 beats (NCH=8, NPIX=16) with m_ready=1 -> m_ch steps every 16 beats, m_last only on beat 127, busy falls after it, and beat 128 shows m_ch=0.
- Hold m_ready=0 for 5 cycles mid-frame -> s_ready=0, outputs frozen, counters unchanged, and no beat lost or duplicated after release.
- Random m_ready/s_valid toggling over 3 frames -> output sequence equals input sequence and channel tags are correct.
- Assert rst_n=0 at beat 50 -> all outputs 0 immediately; after release the first beat is tagged m_ch=0 with params 0.
- Write ch2 mu=7 while busy=1:
  - with BN_PARAM_LOCK_EN: cfg_err pulses and ch2 beats keep the old mu.
  - without: later ch2 beats show mu=7.
